// File: rtl/laser_range_avg_if.sv
// Purpose : Signal bundle between the multi-shot laser range meter and its
//           surroundings (button/photodiode front-end, display/readout).
// Signals : B    - measure button, rising edge starts a burst (to meter)
//           S    - echo sensor, high when a reflection is seen (to meter)
//           L    - laser enable (from meter)
//           D    - last valid distance in cycles/2, D_W bits (from meter)
//           V    - D holds a result of the most recent burst (from meter)
//           E    - most recent burst timed out (from meter)
//           BUSY - meter is not idle (from meter)
// Modports: master = front-end/readout side, slave = meter side.
interface laser_range_avg_if #(
  parameter int D_W = 16
) ();
  logic           B;
  logic           S;
  logic           L;
  logic [D_W-1:0] D;
  logic           V;
  logic           E;
  logic           BUSY;

  modport master (output B, output S, input L, input D, input V, input E, input BUSY);
  modport slave  (input B, input S, output L, output D, output V, output E, output BUSY);
endinterface

// File: rtl/laser_range_avg_fsmd.sv
// Purpose : Multi-shot laser distance meter. A rising edge on B fires a burst
//           of 2**AVG_LOG2 laser shots; each shot counts clock cycles from the
//           end of the laser pulse to the echo on S. The counts are summed and
//           D = sat(sum / 2**(AVG_LOG2+1)) is published with V=1. A shot whose
//           count reaches TIMEOUT without an echo aborts the burst with E=1.
// Ports   : clk    - rising-edge clock
//           reset  - synchronous, active-low reset
//           io_rng - slave modport: B,S in; L,D,V,E,BUSY out
module laser_range_avg_fsmd #(
  parameter int D_W       = 16,
  parameter int CNT_W     = 17,
  parameter int AVG_LOG2  = 2,
  parameter int LASER_CYC = 1,
  parameter int TIMEOUT   = 65535
) (
  input  logic             clk,
  input  logic             reset,
  laser_range_avg_if.slave io_rng
);
  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int LC_W  = (LASER_CYC > 1) ? $clog2(LASER_CYC) : 1;
  localparam int CMP_W = ((SUM_W > D_W) ? SUM_W : D_W) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [LC_W-1:0]  LAST_LC  = LC_W'(LASER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FIRE, COUNT, ACCUM, GAP, DONE, ERR} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_b_q;
  logic [IDX_W-1:0] r_idx;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [LC_W-1:0]  r_lcnt;
  logic [D_W-1:0]   r_d;
  logic             r_v;
  logic             r_e;
  logic             w_start;
  logic             w_l;
  logic             w_busy;

  // Clamp the averaged half-round-trip to the largest value D can show.
  function automatic logic [D_W-1:0] sat_d(input logic [SUM_W-1:0] x);
    logic [CMP_W-1:0] xw;
    xw = CMP_W'(x);
    if (xw > CMP_W'({D_W{1'b1}})) return {D_W{1'b1}};
    return xw[D_W-1:0];
  endfunction

  // Tracks B even while reset is held, so a button already down at reset
  // release is not mistaken for a fresh press.
  always_ff @(posedge clk) begin
    r_b_q <= io_rng.B;
  end

  assign w_start = io_rng.B & ~r_b_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and Moore outputs
  always_comb begin
    w_state_nxt = r_state;
    w_l         = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_start) w_state_nxt = FIRE;
      end
      FIRE: begin
        w_l = 1'b1;
        if (r_lcnt == LAST_LC) w_state_nxt = COUNT;
      end
      // An echo takes priority over timeout on the same cycle.
      COUNT: begin
        if (io_rng.S)              w_state_nxt = ACCUM;
        else if (r_cnt == CNT_MAX) w_state_nxt = ERR;
      end
      ACCUM:   w_state_nxt = (r_idx == LAST_IDX) ? DONE : GAP;
      GAP:     w_state_nxt = FIRE;
      DONE:    w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx  <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_lcnt <= '0;
      r_d    <= '0;
      r_v    <= 1'b0;
      r_e    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_v    <= 1'b0;
            r_e    <= 1'b0;
            r_sum  <= '0;
            r_idx  <= '0;
            r_lcnt <= '0;
          end
        end
        FIRE: begin
          r_cnt  <= '0;
          r_lcnt <= (r_lcnt == LAST_LC) ? '0 : r_lcnt + LC_W'(1);
        end
        // cnt freezes on the echo cycle so ACCUM sees the round-trip count.
        COUNT: begin
          if (!io_rng.S && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
        end
        ACCUM: begin
          r_sum <= r_sum + SUM_W'(r_cnt);
          if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
        end
        // Dividing by 2**AVG_LOG2 averages; the extra bit halves the round trip.
        DONE: begin
          r_d <= sat_d(r_sum >> (AVG_LOG2 + 1));
          r_v <= 1'b1;
        end
        ERR: begin
          r_e <= 1'b1;
          r_v <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io_rng.L    = w_l;
  assign io_rng.BUSY = w_busy;
  assign io_rng.D    = r_d;
  assign io_rng.V    = r_v;
  assign io_rng.E    = r_e;
endmodule
